// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver: frame-synchronous shadow load,
// per-slot anti-ghost blanking, per-digit blink, registered active-low outputs.
module seg7_scan_driver #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [19:0] seg_data,
  input  logic [3:0]  dp_data,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam bit HAS_BLANK  = (BLANK_CYCLES > 0);
  localparam int BLANK_LAST = HAS_BLANK ? BLANK_CYCLES - 1 : 0;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [19:0]   sh_seg_q, sh_seg_d;
  logic [3:0]    sh_dp_q, sh_dp_d;
  logic          pending_q, pending_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick_q, tick_d;

  logic          cnt_wrap, blink_wrap, load, blank;
  logic [4:0]    code;

  function automatic logic [6:0] decode(input logic [4:0] c);
    logic [6:0] p;
    case (c)
      5'd0:    p = 7'b1000000;
      5'd1:    p = 7'b1111001;
      5'd2:    p = 7'b0100100;
      5'd3:    p = 7'b0110000;
      5'd4:    p = 7'b0011001;
      5'd5:    p = 7'b0010010;
      5'd6:    p = 7'b0000010;
      5'd7:    p = 7'b1111000;
      5'd8:    p = 7'b0000000;
      5'd9:    p = 7'b0010000;
      5'd10:   p = 7'b0111111;
      5'd11:   p = 7'b0001000;
      5'd12:   p = 7'b0000011;
      5'd13:   p = 7'b1000110;
      5'd14:   p = 7'b0000110;
      5'd15:   p = 7'b1000001;
      5'd16:   p = 7'b0001100;
      5'd17:   p = 7'b1000111;
      5'd18:   p = 7'b0101111;
      5'd19:   p = 7'b0100001;
      5'd20:   p = 7'b0101011;
      5'd21:   p = 7'b0100011;
      5'd22:   p = 7'b0001001;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  always_comb begin
    cnt_wrap    = (cnt_q == CW'(DIGIT_CYCLES - 1));
    cnt_d       = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d       = cnt_wrap ? idx_q + 2'd1 : idx_q;
    blink_wrap  = (blink_cnt_q == BW'(BLINK_CYCLES - 1));
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    phase_d     = phase_q ^ blink_wrap;

    // Shadows only change at frame boundaries (or right after reset) so a
    // frame never mixes old and new characters.
    load      = pending_q | (cnt_wrap & (idx_q == 2'd3));
    sh_seg_d  = load ? seg_data : sh_seg_q;
    sh_dp_d   = load ? dp_data : sh_dp_q;
    pending_d = 1'b0;
    tick_d    = load;

    case (idx_q)
      2'd0:    code = sh_seg_q[4:0];
      2'd1:    code = sh_seg_q[9:5];
      2'd2:    code = sh_seg_q[14:10];
      default: code = sh_seg_q[19:15];
    endcase

    blank = HAS_BLANK && (cnt_q <= CW'(BLANK_LAST));
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (!blank) begin
      an_d = ~(4'b0001 << idx_q);
      if (!(phase_q && blink_mask[idx_q])) begin
        seg_d = decode(code);
        dp_d  = ~sh_dp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      sh_seg_q    <= 20'hFFFFF;
      sh_dp_q     <= 4'b0000;
      pending_q   <= 1'b1;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      sh_seg_q    <= sh_seg_d;
      sh_dp_q     <= sh_dp_d;
      pending_q   <= pending_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      tick_q      <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (BLANK 2 and 0) checked every
// cycle against a reference model derived from the edge count since reset.
module tb_seg7_scan_driver;

  localparam int D  = 8;
  localparam int BK = 64;
  localparam int FR = 4 * D;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [19:0] seg_data;
  logic [3:0]  dp_data;
  logic [3:0]  blink_mask;
  logic [3:0]  an2, an0;
  logic [6:0]  seg2, seg0;
  logic        dp2, dp0, ft2, ft0;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;
  logic [19:0] m_seg = 20'hFFFFF;
  logic [3:0]  m_dp = 4'b0000;
  logic [25:0] exp_q[$];

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGIT_CYCLES(D), .BLANK_CYCLES(2), .BLINK_CYCLES(BK)) dut (
    .clk(clk), .reset_n(reset_n), .seg_data(seg_data), .dp_data(dp_data),
    .blink_mask(blink_mask), .an(an2), .seg(seg2), .dp(dp2), .frame_tick(ft2));

  seg7_scan_driver #(.DIGIT_CYCLES(D), .BLANK_CYCLES(0), .BLINK_CYCLES(BK)) dut0 (
    .clk(clk), .reset_n(reset_n), .seg_data(seg_data), .dp_data(dp_data),
    .blink_mask(blink_mask), .an(an0), .seg(seg0), .dp(dp0), .frame_tick(ft0));

  // Glyphs described by which segments are lit, then inverted to active-low.
  function automatic logic [6:0] glyph(input logic [4:0] c);
    string s;
    logic [6:0] p;
    int b;
    p = 7'h7F;
    case (c)
      5'd0: s = "abcdef";   5'd1: s = "bc";      5'd2: s = "abdeg";
      5'd3: s = "abcdg";    5'd4: s = "bcfg";    5'd5: s = "acdfg";
      5'd6: s = "acdefg";   5'd7: s = "abc";     5'd8: s = "abcdefg";
      5'd9: s = "abcdfg";   5'd10: s = "g";      5'd11: s = "abcefg";
      5'd12: s = "cdefg";   5'd13: s = "adef";   5'd14: s = "adefg";
      5'd15: s = "bcdef";   5'd16: s = "abefg";  5'd17: s = "def";
      5'd18: s = "eg";      5'd19: s = "bcdeg";  5'd20: s = "ceg";
      5'd21: s = "cdeg";    5'd22: s = "bcefg";
      default: s = "";
    endcase
    for (int i = 0; i < s.len(); i++) begin
      b = int'(s[i]) - 97;
      p[3'(b)] = 1'b0;
    end
    return p;
  endfunction

  // Expected {an, seg, dp, frame_tick} after edge k from the state before it.
  function automatic logic [12:0] model(input int blank);
    int cnt, idx, ph;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_ft;
    logic [19:0] sh;
    cnt = k % D;
    idx = (k / D) % 4;
    ph  = (k / BK) % 2;
    sh  = m_seg >> (idx * 5);
    e_ft = (k == 0) || (k % FR == FR - 1);
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (cnt >= blank) begin
      e_an = 4'hF & ~(4'(1) << idx);
      if (!(ph == 1 && blink_mask[idx])) begin
        e_seg = glyph(sh[4:0]);
        e_dp  = ~m_dp[idx];
      end
    end
    return {e_an, e_seg, e_dp, e_ft};
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_an2"}, {3'b0, an2}, 7'h0F);
    chk({tag, "_seg2"}, seg2, 7'h7F);
    chk({tag, "_dp2"}, {6'b0, dp2}, 7'h01);
    chk({tag, "_ft2"}, {6'b0, ft2}, 7'h00);
    chk({tag, "_an0"}, {3'b0, an0}, 7'h0F);
    chk({tag, "_seg0"}, seg0, 7'h7F);
  endtask

  task automatic tick();
    logic [25:0] e;
    @(posedge clk);
    exp_q.push_back({model(2), model(0)});
    if (k == 0 || k % FR == FR - 1) begin
      m_seg = seg_data;
      m_dp  = dp_data;
    end
    @(negedge clk);
    e = exp_q.pop_front();
    chk("an_b2", {3'b0, an2}, {3'b0, e[25:22]});
    chk("seg_b2", seg2, e[21:15]);
    chk("dp_b2", {6'b0, dp2}, {6'b0, e[14]});
    chk("ft_b2", {6'b0, ft2}, {6'b0, e[13]});
    chk("an_b0", {3'b0, an0}, {3'b0, e[12:9]});
    chk("seg_b0", seg0, e[8:2]);
    chk("dp_b0", {6'b0, dp0}, {6'b0, e[1]});
    chk("ft_b0", {6'b0, ft0}, {6'b0, e[0]});
    k++;
  endtask

  task automatic restart();
    reset_n = 1'b1;
    k = 0;
    m_seg = 20'hFFFFF;
    m_dp = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog k=%0d observed=timeout expected=finish", k);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    seg_data = {5'd1, 5'd2, 5'd10, 5'd31};
    dp_data = 4'b0100;
    blink_mask = 4'b0000;
    repeat (2) @(negedge clk);
    check_idle("reset");
    restart();

    // Known frame, then a mid-frame data change that must wait for the boundary.
    for (int i = 0; i < 45; i++) tick();
    seg_data = {5'd9, 5'd0, 5'd0, 5'd19};
    dp_data = 4'b0000;
    for (int i = 0; i < 60; i++) tick();

    // Blink on digit 0 across several phases.
    blink_mask = 4'b0001;
    for (int i = 0; i < 200; i++) tick();

    // Random characters, dots and masks.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        seg_data = 20'($urandom);
        dp_data = 4'($urandom);
      end
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
      tick();
    end

    // Asynchronous reset mid-slot, observed before any clock edge.
    while (k % D != 5) tick();
    #2 reset_n = 1'b0;
    #1 check_idle("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("held_rst");
    seg_data = {5'd22, 5'd14, 5'd17, 5'd16};
    dp_data = 4'b1001;
    blink_mask = 4'b0000;
    restart();
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 9) == 0) seg_data = 20'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
